// File: rtl/rx_word_unloader_pkg.sv
// Shared constants for the PC receive word path and its unloader.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package rx_word_unloader_pkg;

  localparam int WORD_W          = 32;
  localparam int FRAME_WORDS_DEF = 1024;
  // Cycles from rdreq to q being valid on the receive FIFO (non-show-ahead).
  localparam int RD_LATENCY      = 1;

  typedef logic [WORD_W-1:0] word_t;

  // Number of reads currently travelling through the FIFO read pipeline.
  function automatic logic [2:0] count_inflight(input logic [RD_LATENCY-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rx_skid_buffer.sv
// Two-entry push/pop word FIFO absorbing the receive FIFO read latency.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller never pushes into a full buffer without a pop.
module rx_skid_buffer
  import rx_word_unloader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  word_t      push_dat,
  input  logic       pop,
  output logic [1:0] occ,
  output word_t      head_dat
);

  word_t      mem_q [2];
  word_t      mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign occ      = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and count; a push into a full buffer only lands alongside a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (cnt_q != 2'd0);
    do_push  = push && ((cnt_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // State registers; reset zeroes storage so the head reads 0 while empty after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_word_unloader.sv
// Pops the receive word FIFO and presents words as a valid/ready stream tagged with a frame address.
// Latency: rdreq at cycle N gives o_word_valid at N+2; 1 word/cycle sustained with ready high.
// Backpressure: stops issuing reads once skid occupancy plus in-flight reads would exceed 2.
module rx_word_unloader
  import rx_word_unloader_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = 10,
  parameter int FCNT_W      = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_fifo_empty,
  input  logic [WORD_W-1:0] i_fifo_word,
  output logic              o_fifo_rdreq,
  input  logic              i_frame_restart,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word_data,
  output logic [ADDR_W-1:0] o_word_addr,
  input  logic              i_word_ready,
  output logic              o_frame_done,
  output logic [FCNT_W-1:0] o_frame_count,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]     frame_count_q, frame_count_d;
  logic [1:0]            occ;
  logic                  xfer;
  logic [2:0]            pending;

  rx_skid_buffer u_skid (
    .clk      (i_clock),
    .rst      (i_reset),
    .push     (inflight_q[RD_LATENCY-1]),
    .push_dat (i_fifo_word),
    .pop      (xfer),
    .occ      (occ),
    .head_dat (o_word_data)
  );

  assign o_word_valid  = (occ != 2'd0);
  assign xfer          = o_word_valid && i_word_ready;
  assign o_word_addr   = addr_q;
  assign o_frame_done  = frame_done_q;
  assign o_frame_count = frame_count_q;
  assign o_busy        = (|inflight_q) || (occ != 2'd0);

  // Read only when the word will find room: a word leaving this cycle frees its slot.
  always_comb begin
    pending      = {1'b0, occ} - {2'b00, xfer} + count_inflight(inflight_q);
    o_fifo_rdreq = !i_fifo_empty && !i_reset && (pending < 3'd2);
    inflight_d    = '0;
    inflight_d[0] = o_fifo_rdreq;
    for (int i = 1; i < RD_LATENCY; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
  end

  // Address advances per transfer; restart beats increment and wrap, but a wrap still counts a frame.
  always_comb begin
    addr_d        = addr_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    if (xfer) begin
      if (addr_q == LAST_ADDR) begin
        addr_d        = '0;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
    if (i_frame_restart) begin
      addr_d = '0;
    end
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      inflight_q    <= '0;
      addr_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      inflight_q    <= inflight_d;
      addr_q        <= addr_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_rx_word_unloader.sv
// Directed bench for rx_word_unloader with a FIFO model and a stream scoreboard.
// Latency: n/a.
// Backpressure: ready driven per step; FIFO model honours rdreq with 1-cycle q latency.
module tb_rx_word_unloader;

  localparam int FW = 4;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_fifo_empty;
  logic [31:0] i_fifo_word = 32'd0;
  logic        o_fifo_rdreq;
  logic        i_frame_restart = 1'b0;
  logic        o_word_valid;
  logic [31:0] o_word_data;
  logic [1:0]  o_word_addr;
  logic        i_word_ready = 1'b0;
  logic        o_frame_done;
  logic [15:0] o_frame_count;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: initial block writes, posedge process reads.
  logic [31:0] fifo_mem [0:16383];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign i_fifo_empty = (wr_cnt == rd_cnt);

  // Scoreboard state, owned by the monitor.
  int exp_rd = 0;
  int exp_addr = 0;
  int exp_fcount = 0;
  logic exp_done = 1'b0;
  int done_cnt = 0;
  logic mon_en = 1'b0;

  always #10 clk = ~clk;

  rx_word_unloader #(.FRAME_WORDS(FW), .ADDR_W(2), .FCNT_W(16)) dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_fifo_empty    (i_fifo_empty),
    .i_fifo_word     (i_fifo_word),
    .o_fifo_rdreq    (o_fifo_rdreq),
    .i_frame_restart (i_frame_restart),
    .o_word_valid    (o_word_valid),
    .o_word_data     (o_word_data),
    .o_word_addr     (o_word_addr),
    .i_word_ready    (i_word_ready),
    .o_frame_done    (o_frame_done),
    .o_frame_count   (o_frame_count),
    .o_busy          (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_cnt] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_rd != wr_cnt && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 32'(exp_rd), 32'(wr_cnt));
  endtask

  // FIFO read port: q valid the cycle after rdreq.
  always @(posedge clk) begin
    if (o_fifo_rdreq && (rd_cnt != wr_cnt)) begin
      i_fifo_word <= fifo_mem[rd_cnt];
      rd_cnt      <= rd_cnt + 1;
    end
  end

  // Stream monitor: transfers decided at the negedge happen at the following posedge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rdreq_while_empty", 32'(o_fifo_rdreq && i_fifo_empty), 32'd0);
      check("frame_done", 32'(o_frame_done), 32'(exp_done));
      check("frame_count", 32'(o_frame_count), 32'(exp_fcount % 65536));
      if (o_frame_done) done_cnt++;
      exp_done = 1'b0;
      if (i_reset) begin
        exp_addr   = 0;
        exp_fcount = 0;
        exp_rd     = rd_cnt;
      end else if (o_word_valid && i_word_ready) begin
        if (exp_rd < wr_cnt) begin
          check("word_data", o_word_data, fifo_mem[exp_rd]);
        end else begin
          check("extra_word", 32'(exp_rd), 32'(wr_cnt - 1));
        end
        check("word_addr", 32'(o_word_addr), 32'(exp_addr));
        exp_rd++;
        if (exp_addr == FW - 1) begin
          exp_done = 1'b1;
          exp_fcount++;
        end
        exp_addr = (i_frame_restart || exp_addr == FW - 1) ? 0 : exp_addr + 1;
      end else if (i_frame_restart) begin
        exp_addr = 0;
      end
    end
  end

  initial begin
    int n_rdreq;
    int d0;
    int k;
    logic [31:0] held_dat;

    // Reset state
    repeat (2) cyc();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_rdreq", 32'(o_fifo_rdreq), 32'd0);
    check("rst_valid", 32'(o_word_valid), 32'd0);
    check("rst_data", o_word_data, 32'd0);
    check("rst_addr", 32'(o_word_addr), 32'd0);
    check("rst_done", 32'(o_frame_done), 32'd0);
    check("rst_count", 32'(o_frame_count), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    cyc();
    i_reset = 1'b0;

    // Three words, ready high: rdreq at 0,1,2; words at 2,3,4
    cyc();
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h33333333);
    i_word_ready = 1'b1;
    @(negedge clk);
    check("t1_c0_rdreq", 32'(o_fifo_rdreq), 32'd1);
    check("t1_c0_valid", 32'(o_word_valid), 32'd0);
    @(negedge clk);
    check("t1_c1_rdreq", 32'(o_fifo_rdreq), 32'd1);
    check("t1_c1_valid", 32'(o_word_valid), 32'd0);
    @(negedge clk);
    check("t1_c2_rdreq", 32'(o_fifo_rdreq), 32'd1);
    check("t1_c2_valid", 32'(o_word_valid), 32'd1);
    check("t1_c2_data", o_word_data, 32'h11111111);
    check("t1_c2_addr", 32'(o_word_addr), 32'd0);
    @(negedge clk);
    check("t1_c3_rdreq", 32'(o_fifo_rdreq), 32'd0);
    check("t1_c3_data", o_word_data, 32'h22222222);
    check("t1_c3_addr", 32'(o_word_addr), 32'd1);
    @(negedge clk);
    check("t1_c4_data", o_word_data, 32'h33333333);
    check("t1_c4_addr", 32'(o_word_addr), 32'd2);
    @(negedge clk);
    check("t1_c5_valid", 32'(o_word_valid), 32'd0);
    check("t1_c5_busy", 32'(o_busy), 32'd0);

    // Ready low with 5 words queued: exactly two reads, head held stable
    cyc();
    i_word_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'hA0000000 + 32'(i));
    n_rdreq = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_fifo_rdreq) n_rdreq++;
    end
    check("t2_rdreq_pulses", 32'(n_rdreq), 32'd2);
    check("t2_valid", 32'(o_word_valid), 32'd1);
    check("t2_data", o_word_data, 32'hA0000000);
    check("t2_addr", 32'(o_word_addr), 32'd3);
    held_dat = o_word_data;
    @(negedge clk);
    check("t2_data_stable", o_word_data, held_dat);
    check("t2_addr_stable", 32'(o_word_addr), 32'd3);
    cyc();
    i_word_ready = 1'b1;
    drain("t2_drain", 50);

    // Clean start for the frame tests
    cyc();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;

    // Nine words, random ready: two frames completed
    d0 = done_cnt;
    for (int i = 0; i < 9; i++) push_word(32'hB0000000 + 32'(i));
    k = 0;
    while (exp_rd != wr_cnt && k < 200) begin
      i_word_ready = 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    check("t3_drain", 32'(exp_rd), 32'(wr_cnt));
    i_word_ready = 1'b0;
    repeat (3) cyc();
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("t3_frame_count", 32'(o_frame_count), 32'd2);
    check("t3_next_addr", 32'(o_word_addr), 32'd1);

    // Restart coinciding with the addr-2 transfer
    for (int i = 0; i < 4; i++) push_word(32'hC0000000 + 32'(i));
    repeat (4) cyc();
    i_word_ready = 1'b1;
    cyc();
    i_word_ready = 1'b0;
    cyc();
    check("t4_pre_addr", 32'(o_word_addr), 32'd2);
    i_word_ready = 1'b1;
    i_frame_restart = 1'b1;
    cyc();
    i_frame_restart = 1'b0;
    i_word_ready = 1'b0;
    @(negedge clk);
    check("t4_valid", 32'(o_word_valid), 32'd1);
    check("t4_data", o_word_data, 32'hC0000002);
    check("t4_addr", 32'(o_word_addr), 32'd0);
    check("t4_no_done", 32'(o_frame_done), 32'd0);
    cyc();
    i_word_ready = 1'b1;
    drain("t4_drain", 50);
    repeat (2) cyc();
    check("t4_frame_count", 32'(o_frame_count), 32'd2);

    // Reset one cycle after a rdreq with one word buffered
    i_word_ready = 1'b0;
    cyc();
    push_word(32'hD0000000);
    push_word(32'hD0000001);
    push_word(32'hD0000002);
    push_word(32'hD0000003);
    cyc();
    cyc();
    i_reset = 1'b1;
    @(negedge clk);
    check("t5_pre_valid", 32'(o_word_valid), 32'd1);
    check("t5_pre_busy", 32'(o_busy), 32'd1);
    cyc();
    @(negedge clk);
    check("t5_rdreq", 32'(o_fifo_rdreq), 32'd0);
    check("t5_valid", 32'(o_word_valid), 32'd0);
    check("t5_data", o_word_data, 32'd0);
    check("t5_addr", 32'(o_word_addr), 32'd0);
    check("t5_count", 32'(o_frame_count), 32'd0);
    check("t5_busy", 32'(o_busy), 32'd0);
    cyc();
    i_reset = 1'b0;
    i_word_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!o_word_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("t5_next_valid", 32'(o_word_valid), 32'd1);
    check("t5_next_data", o_word_data, 32'hD0000002);
    check("t5_next_addr", 32'(o_word_addr), 32'd0);
    cyc();
    drain("t5_drain", 50);

    // Random empty/ready stress
    for (int n = 0; n < 10000; ) begin
      if ($urandom_range(0, 3) != 0) begin
        push_word($urandom);
        n++;
      end
      i_word_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    i_word_ready = 1'b1;
    drain("t6_drain", 20000);
    repeat (3) cyc();
    check("t6_idle_busy", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
